// File: rtl/morse_transmitter.sv
// Sends one letter (A..H) as Morse on Light; Light/Busy are registered and rise on the edge that accepts Start.
// Start is only sampled in IDLE, so requests during a letter are dropped rather than queued.
module morse_transmitter #(
   parameter int UNIT_CYCLES = 25000000
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic [2:0] Letter,
   input  logic       Start,
   output logic       Light,
   output logic       Busy
);

   localparam int CW = $clog2(3 * UNIT_CYCLES);
   localparam logic [CW-1:0] DOT_LAST  = CW'(UNIT_CYCLES - 1);
   localparam logic [CW-1:0] DASH_LAST = CW'(3 * UNIT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    pat_q, pat_d;
   logic [2:0]    len_q, len_d;
   logic          light_q, light_d;
   logic          busy_q, busy_d;

   // Pattern is left-aligned: bit 3 is the element currently being sent.
   function automatic logic [6:0] encode(input logic [2:0] l);
      case (l)
         3'd0:    encode = {4'b0100, 3'd2};
         3'd1:    encode = {4'b1000, 3'd4};
         3'd2:    encode = {4'b1010, 3'd4};
         3'd3:    encode = {4'b1000, 3'd3};
         3'd4:    encode = {4'b0000, 3'd1};
         3'd5:    encode = {4'b0010, 3'd4};
         3'd6:    encode = {4'b1100, 3'd3};
         default: encode = {4'b0000, 3'd4};
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      pat_d   = pat_q;
      len_d   = len_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (Start) begin
               {pat_d, len_d} = encode(Letter);
               state_d        = ON;
            end
         end
         ON: begin
            if (cnt_q == (pat_q[3] ? DASH_LAST : DOT_LAST)) begin
               cnt_d   = '0;
               state_d = GAP;
            end
         end
         GAP: begin
            if (cnt_q == DOT_LAST) begin
               cnt_d   = '0;
               pat_d   = {pat_q[2:0], 1'b0};
               len_d   = len_q - 3'd1;
               state_d = (len_q > 3'd1) ? ON : IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
      light_d = (state_d == ON);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pat_q   <= '0;
         len_q   <= '0;
         light_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         light_q <= light_d;
         busy_q  <= busy_d;
      end
   end

   assign Light = light_q;
   assign Busy  = busy_q;

endmodule

// File: tb/tb_morse_transmitter.sv
// Scoreboard bench: accepted letters expand into per-cycle {Busy,Light} expectations consumed by a monitor.
module tb_morse_transmitter;
   localparam int U = 4;

   logic       Clock  = 1'b0;
   logic       Resetn = 1'b0;
   logic       Start  = 1'b0;
   logic [2:0] Letter = 3'd0;
   logic       Light, Busy;

   int vectors     = 0;
   int miscompares = 0;

   logic [1:0] exp_q[$];
   string code [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

   morse_transmitter #(.UNIT_CYCLES(U)) dut (
      .Clock (Clock),
      .Resetn(Resetn),
      .Letter(Letter),
      .Start (Start),
      .Light (Light),
      .Busy  (Busy)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [1:0] got, input logic [1:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s at %0t: got {Busy,Light}=%b expected %b", name, $time, got, want);
      end
   endtask

   // Each element is on for U or 3U cycles followed by U off; one idle cycle closes the letter.
   task automatic push_letter(input logic [2:0] l);
      string s;
      int    on;
      s = code[l];
      for (int i = 0; i < s.len(); i++) begin
         on = (s[i] == "-") ? 3 * U : U;
         repeat (on) exp_q.push_back(2'b11);
         repeat (U) exp_q.push_back(2'b10);
      end
      exp_q.push_back(2'b00);
   endtask

   always @(posedge Clock or negedge Resetn) begin
      if (!Resetn) exp_q.delete();
      else if (Start && exp_q.size() == 0) push_letter(Letter);
   end

   always @(negedge Clock) begin
      logic [1:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;
      check("out", {Busy, Light}, e);
   end

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 300) begin
         @(negedge Clock);
         n++;
      end
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d entries left after %0d cycles, expected 0", exp_q.size(), n);
         exp_q.delete();
      end
      @(negedge Clock);
   endtask

   task automatic send(input logic [2:0] l);
      @(negedge Clock);
      Letter = l;
      Start  = 1'b1;
      @(negedge Clock);
      Start  = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge Clock);
      #1 check("reset_state", {Busy, Light}, 2'b00);

      // Start on the very first edge after release.
      @(negedge Clock);
      Resetn = 1'b1;
      Letter = 3'd4;
      Start  = 1'b1;
      @(negedge Clock);
      Start  = 1'b0;
      drain();

      for (int l = 0; l < 8; l++) begin
         send(3'(l));
         drain();
      end

      // Requests during a letter are ignored and the in-flight letter is unaffected.
      send(3'd0);
      repeat (6) @(negedge Clock);
      Letter = 3'd7;
      Start  = 1'b1;
      @(negedge Clock);
      Start  = 1'b0;
      drain();
      repeat (10) @(negedge Clock);

      // Asynchronous abort two cycles into the first dash of G.
      send(3'd6);
      @(posedge Clock);
      #3 Resetn = 1'b0;
      #1 check("async_reset", {Busy, Light}, 2'b00);
      repeat (2) @(negedge Clock);
      Resetn = 1'b1;
      repeat (50) @(negedge Clock);

      // Start held high repeats E back to back.
      Letter = 3'd4;
      Start  = 1'b1;
      repeat (45) @(negedge Clock);
      Start  = 1'b0;
      drain();

      for (int i = 0; i < 600; i++) begin
         @(negedge Clock);
         Start  = ($urandom_range(0, 9) == 0);
         Letter = 3'($urandom_range(0, 7));
      end
      Start = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
